// File: rtl/rx_pkg.sv
// rx_pkg: shared constants, FSM state type and saturating magnitude helper
// for the rx_phase_slicer receiver front stage.
// No ports. Pure declarations, no timing or flow control of its own.
package rx_pkg;

  // Oversampling ratio of the incoming stream (samples per symbol).
  localparam int OS      = 4;
  localparam int OS_LOG2 = 2;

  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } rx_state_e;

  // |x| for an nb-bit two's complement value held sign-extended in 32 bits.
  // The most negative code has no positive twin, so it saturates to
  // 2^(nb-1)-1. The result fits in nb-1 bits.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] x,
                                          input int unsigned       nb);
    logic signed [31:0] most_neg;
    most_neg = -(32'sd1 <<< (nb - 1));
    if (x == most_neg) return $unsigned(-(most_neg + 32'sd1));
    if (x < 0) return $unsigned(-x);
    return $unsigned(x);
  endfunction

endpackage

// File: rtl/rx_energy_acc.sv
// rx_energy_acc: per-phase magnitude accumulator for the phase estimator.
// Latency: accumulated value visible 1 clk after the enabled add.
// Backpressure: none; adds only when enable is high, clear wins over add.
// Ports: clk, rst (sync, active high), enable (add this cycle),
//        clear (load zero this cycle), i_magnitude (unsigned), o_accumulator.
module rx_energy_acc #(
  parameter int MAG_W = 15,
  parameter int ACC_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [MAG_W-1:0] i_magnitude,
  output logic [ACC_W-1:0] o_accumulator
);

  logic [ACC_W-1:0] acc_d, acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = acc_q + ACC_W'(i_magnitude);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_accumulator = acc_q;

endmodule

// File: rtl/rx_phase_slicer.sv
// rx_phase_slicer: picks the best of 4 sampling phases by windowed magnitude
// energy, decimates to 1 sample/symbol and slices the sign to a bit.
// Latency 1 clk from selected sample to o_bit; no backpressure, i_valid gaps
// simply pause every counter.
// Ports: clk, rst (sync, active high); i_sample/i_valid input stream;
//        i_auto / i_phase_man phase mode; o_bit/o_bit_valid sliced output;
//        o_phase phase in use; o_locked auto-mode lock indication.
module rx_phase_slicer #(
  parameter int NB_SAMPLE = 16,
  parameter int WIN_LOG2  = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [NB_SAMPLE-1:0] i_sample,
  input  logic                        i_valid,
  input  logic                        i_auto,
  input  logic [1:0]                  i_phase_man,
  output logic                        o_bit,
  output logic                        o_bit_valid,
  output logic [1:0]                  o_phase,
  output logic                        o_locked
);
  import rx_pkg::*;

  localparam int MAG_W = NB_SAMPLE - 1;
  localparam int ACC_W = NB_SAMPLE - 1 + WIN_LOG2;

  logic [OS_LOG2-1:0]  ph_cnt_d, ph_cnt_q;
  logic [WIN_LOG2-1:0] sym_cnt_d, sym_cnt_q;
  logic [1:0]          phase_est_d, phase_est_q;
  logic [1:0]          sel_d, sel_q;
  rx_state_e           state_d, state_q;
  logic                bit_d, bit_q;
  logic                bit_vld_d, bit_vld_q;

  logic [MAG_W-1:0]    mag;
  logic [OS-1:0]       acc_en;
  logic [ACC_W-1:0]    acc_val [OS];
  logic [ACC_W-1:0]    acc_tot [OS];
  logic [ACC_W-1:0]    best_val;
  logic [1:0]          best_idx;
  logic                boundary;
  logic                win_end;

  assign mag      = MAG_W'(sat_abs(32'(i_sample), NB_SAMPLE));
  assign boundary = i_valid && (ph_cnt_q == OS_LOG2'(OS - 1));
  assign win_end  = boundary && (sym_cnt_q == '1);

  for (genvar p = 0; p < OS; p++) begin : g_acc
    assign acc_en[p] = i_valid && (ph_cnt_q == OS_LOG2'(p));

    rx_energy_acc #(
      .MAG_W (MAG_W),
      .ACC_W (ACC_W)
    ) u_acc (
      .clk           (clk),
      .rst           (rst),
      .enable        (acc_en[p]),
      .clear         (win_end),
      .i_magnitude   (mag),
      .o_accumulator (acc_val[p])
    );
  end

  // The decision must see the sample arriving on the window-end cycle, which
  // the accumulator flops have not absorbed yet (and never will, since that
  // same cycle clears them).
  always_comb begin
    for (int p = 0; p < OS; p++) begin
      acc_tot[p] = acc_val[p] + (acc_en[p] ? ACC_W'(mag) : '0);
    end
  end

  // Strict greater-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = acc_tot[0];
    for (int p = 1; p < OS; p++) begin
      if (acc_tot[p] > best_val) begin
        best_val = acc_tot[p];
        best_idx = 2'(p);
      end
    end
  end

  always_comb begin
    ph_cnt_d    = ph_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    phase_est_d = phase_est_q;
    sel_d       = sel_q;
    state_d     = state_q;
    bit_d       = bit_q;
    bit_vld_d   = 1'b0;

    if (i_valid) begin
      ph_cnt_d = ph_cnt_q + OS_LOG2'(1);

      // In auto mode no bit is produced until a full window has been seen.
      if ((ph_cnt_q == sel_q) && ((state_q == LOCKED) || !i_auto)) begin
        bit_vld_d = 1'b1;
        bit_d     = ~i_sample[NB_SAMPLE-1];
      end

      if (boundary) begin
        sym_cnt_d = sym_cnt_q + WIN_LOG2'(1);
        if (win_end) begin
          phase_est_d = best_idx;
          if (i_auto) begin
            state_d = LOCKED;
          end
        end
        // Phase only moves here, so a symbol can never yield 0 or 2 bits.
        sel_d = i_auto ? phase_est_d : i_phase_man;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_cnt_q    <= '0;
      sym_cnt_q   <= '0;
      phase_est_q <= '0;
      sel_q       <= '0;
      state_q     <= ACQUIRE;
      bit_q       <= 1'b0;
      bit_vld_q   <= 1'b0;
    end else begin
      ph_cnt_q    <= ph_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      phase_est_q <= phase_est_d;
      sel_q       <= sel_d;
      state_q     <= state_d;
      bit_q       <= bit_d;
      bit_vld_q   <= bit_vld_d;
    end
  end

  assign o_bit       = bit_q;
  assign o_bit_valid = bit_vld_q;
  assign o_phase     = sel_q;
  assign o_locked    = (state_q == LOCKED) && i_auto;

endmodule

// File: doc/rx_phase_slicer.md
# rx_phase_slicer

Receiver front stage that consumes the 4-samples-per-symbol signed stream produced by the transmit pulse-shaping filter (directly or through the channel model). It estimates the optimum sampling phase by accumulating per-phase magnitude over a window of symbols, then decimates to one sample per symbol and slices the sign to a bit. The bit stream and strobe feed the downstream BER checker.

## Interface
Parameters:
- NB_SAMPLE, 16: input sample width, signed two's complement.
- WIN_LOG2, 10: estimation window of 2^WIN_LOG2 symbols.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_sample  in  NB_SAMPLE  signed sample from the transmit filter.
- i_valid  in  1  sample strobe; the block ignores i_sample when it is low.
- i_auto  in  1  1 = automatic phase selection, 0 = use i_phase_man.
- i_phase_man  in  2  manual sampling phase (0..3).
- o_bit  out  1  sliced bit, registered.
- o_bit_valid  out  1  one-cycle strobe qualifying o_bit.
- o_phase  out  2  phase currently in use.
- o_locked  out  1  auto mode: at least one window has completed since reset.

## Operation
- ph_cnt (2 b): increments modulo 4 on each i_valid. The symbol boundary is the i_valid cycle with ph_cnt==3.
- sym_cnt (WIN_LOG2 b): increments at each symbol boundary and wraps at 2^WIN_LOG2.
- Magnitude: |i_sample|, saturated, so −2^(NB_SAMPLE−1) maps to 2^(NB_SAMPLE−1)−1. Result width is NB_SAMPLE−1 unsigned.
- acc[p], p=0..3: unsigned, NB_SAMPLE−1+WIN_LOG2 bits. On i_valid with ph_cnt==p, acc[p] += magnitude. No overflow is possible at this width.
- Window end is the symbol boundary with sym_cnt==2^WIN_LOG2−1. On that cycle:
  - phase_est ← index of the largest acc. On a tie, the lowest index wins. The comparison includes the sample being added in that same cycle.
  - All acc are cleared to 0. The cleared value replaces the add.
- FSM, evaluated only when i_auto=1:
  - ACQUIRE: entered from reset.
  - On window end, go to LOCKED.
  - LOCKED: stays LOCKED. phase_est still updates at every window end.
- Phase in use (sel): i_auto ? phase_est : i_phase_man.
  - sel may only change at a symbol boundary. The registered copy updates there, so every symbol yields exactly one bit.
  - A change on i_phase_man or i_auto in the middle of a symbol is deferred to the next boundary.
- Slicer: on i_valid with ph_cnt==sel, and with (state==LOCKED or i_auto=0):
  - o_bit ← ~i_sample[MSB], so a sample ≥0 gives 1.
  - o_bit_valid ← 1.
- o_locked = (state==LOCKED). It is 0 when i_auto=0, but the FSM state is retained.

## Timing
- Reset values: o_bit=0, o_bit_valid=0, o_phase=0, o_locked=0, ph_cnt=0, sym_cnt=0, all acc=0, phase_est=0, sel register=0, state ACQUIRE.
- Latency: o_bit and o_bit_valid appear 1 clk after the selected i_valid sample.
- o_bit_valid is high for exactly 1 cycle per symbol. Gaps in i_valid stretch the symbol period and pause all counters.
- o_phase and o_locked update 1 clk after the window-end sample.
- The first auto bit comes from the symbol after the first window: sample index 4·2^WIN_LOG2 + phase_est.
- Reset asserted at any time, including mid-window or mid-symbol, returns every register to its reset value on the next edge. The partial window is discarded.
- rst has priority over i_valid in the same cycle.

## Structure
- Shared package rx_pkg:
  - OS=4 and OS_LOG2=2.
  - FSM state enumeration {ACQUIRE, LOCKED}.
  - Saturating abs function.
- Sub-module rx_energy_acc, instantiated four times. Ports: clk, rst, enable, clear, magnitude in, accumulator out.
- Top level holds the counters, FSM, max-of-four comparator, sel register and slicer.

## Test plan
- WIN_LOG2=2, auto; repeating pattern {100, 200, 3000, −50}, signs alternating per symbol -> o_locked rises after sample 16; o_phase=2; bits alternate and match the sign of the phase-2 samples; one o_bit_valid per 4 samples.
- Auto; all samples equal to +500 -> tie resolves to o_phase=0; all bits 1.
- Auto; samples −32768 on phase 1 only, others 0 -> o_phase=1 with accumulator value 4·32767; bits all 0.
- Manual, i_phase_man=3; i_phase_man changed to 1 at ph_cnt==1 -> the old phase is used for the current symbol and the new phase from the next boundary; never 0 or 2 strobes in one symbol.
- i_valid toggled 1-0-0-1… with the first test's pattern -> same bit sequence as the first test; o_bit_valid spacing follows the valid count.
- rst asserted for 1 cycle mid-window after lock -> all outputs 0 next cycle; re-acquisition takes a full new window.
